// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target predictor with per-entry saturating counters.
// After reset the table's valid bits are swept clear one entry per cycle (INIT).
// Only then are lookups and updates served (RUN).

// One table entry. It holds its own state and applies the update rule when selected.
module btp_entry #(
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 8,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              upd,
  input  logic              up_taken,
  input  logic [TAG_W-1:0]  up_tag,
  input  logic [ADDR_W-1:0] up_target,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [CTR_W-1:0]  ctr,
  output logic [ADDR_W-1:0] target
);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);

  logic upd_hit;
  assign upd_hit = valid && (tag == up_tag);

  // Clear during INIT, train on a hit, allocate on a taken miss.
  // Tag, counter and target are never reset. The valid bit gates them.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= 1'b0;
    end else if (upd) begin
      if (upd_hit) begin
        if (up_taken) begin
          if (ctr != CTR_MAX) ctr <= ctr + CTR_W'(1);
          target <= up_target;
        end else if (ctr != '0) begin
          ctr <= ctr - CTR_W'(1);
        end
      end else if (up_taken) begin
        valid  <= 1'b1;
        tag    <= up_tag;
        ctr    <= CTR_WEAK;
        target <= up_target;
      end
    end
  end
endmodule

module branch_target_predictor #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 8,
  parameter int CTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              up_valid,
  input  logic [ADDR_W-1:0] up_pc,
  input  logic [ADDR_W-1:0] up_target,
  input  logic              up_taken,
  input  logic              up_pred_taken,
  output logic              busy,
  output logic [15:0]       stat_updates,
  output logic [15:0]       stat_mispredicts
);
  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  init_idx, idx_nx;

  logic [DEPTH-1:0]             e_valid;
  logic [DEPTH-1:0][TAG_W-1:0]  e_tag;
  logic [DEPTH-1:0][CTR_W-1:0]  e_ctr;
  logic [DEPTH-1:0][ADDR_W-1:0] e_target;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_accept;
  logic             unused_bits;

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = up_pc[IDX_W+1:2];
  assign up_tag = up_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Low PC bits and any bits above the tag do not take part in indexing.
  assign unused_bits = ^{lk_pc, up_pc, e_ctr};

  // Reset also forces busy, so no lookup hits and no update lands while reset is held.
  assign busy      = reset || (state == INIT);
  assign up_accept = up_valid && !busy;

  // State register and sweep pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nx;
      init_idx <= idx_nx;
    end
  end

  // The sweep visits entries 0..DEPTH-1 and then hands over to RUN.
  always_comb begin
    state_nx = state;
    idx_nx   = init_idx;
    case (state)
      INIT: begin
        idx_nx = init_idx + IDX_W'(1);
        if (init_idx == IDX_W'(DEPTH - 1)) state_nx = RUN;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    btp_entry #(.ADDR_W(ADDR_W), .TAG_W(TAG_W), .CTR_W(CTR_W)) u_entry (
      .clk       (clk),
      .clr       ((state == INIT) && (init_idx == IDX_W'(i))),
      .upd       (up_accept && (up_idx == IDX_W'(i))),
      .up_taken  (up_taken),
      .up_tag    (up_tag),
      .up_target (up_target),
      .valid     (e_valid[i]),
      .tag       (e_tag[i]),
      .ctr       (e_ctr[i]),
      .target    (e_target[i])
    );
  end

  // Lookup reads the registered table. A same-cycle update is not visible until the next edge.
  always_comb begin
    pred_hit    = !busy && e_valid[lk_idx] && (e_tag[lk_idx] == lk_tag);
    pred_taken  = pred_hit && e_ctr[lk_idx][CTR_W-1];
    pred_target = pred_taken ? e_target[lk_idx] : '0;
  end

  // Event counters. Each saturates at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (up_accept) begin
      if (stat_updates != 16'hFFFF) stat_updates <= stat_updates + 16'd1;
      if ((up_taken != up_pred_taken) && (stat_mispredicts != 16'hFFFF))
        stat_mispredicts <= stat_mispredicts + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor.
// Lookup expectations go into a scoreboard queue when stimulus is driven.
// They are popped and checked against the DUT outputs mid-cycle.
module tb_branch_target_predictor;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] lk_pc = '0;
  logic              pred_hit, pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              up_valid = 1'b0;
  logic [ADDR_W-1:0] up_pc = '0, up_target = '0;
  logic              up_taken = 1'b0, up_pred_taken = 1'b0;
  logic              busy;
  logic [15:0]       stat_updates, stat_mispredicts;

  branch_target_predictor #(.ADDR_W(32), .IDX_W(4), .TAG_W(8), .CTR_W(2)) dut (
    .clk(clk), .reset(reset), .lk_pc(lk_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .up_valid(up_valid), .up_pc(up_pc), .up_target(up_target),
    .up_taken(up_taken), .up_pred_taken(up_pred_taken),
    .busy(busy), .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } lk_exp_t;

  lk_exp_t sb_q[$];
  string   sb_name_q[$];
  int      n_chk  = 0;
  int      n_fail = 0;
  int      exp_upd = 0;
  int      exp_mis = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic expect_lk(input string name, input logic h, input logic t, input logic [31:0] tg);
    lk_exp_t e;
    e.hit = h; e.taken = t; e.target = tg;
    sb_q.push_back(e);
    sb_name_q.push_back(name);
  endtask

  task automatic check_lk();
    lk_exp_t e;
    string   nm;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e  = sb_q.pop_front();
    nm = sb_name_q.pop_front();
    chk({nm, "_hit"},    {31'd0, pred_hit},   {31'd0, e.hit});
    chk({nm, "_taken"},  {31'd0, pred_taken}, {31'd0, e.taken});
    chk({nm, "_target"}, pred_target,         e.target);
  endtask

  // Drive the lookup PC at the falling edge, then check it once the outputs settle.
  task automatic lookup(input string name, input logic [31:0] pc,
                        input logic h, input logic t, input logic [31:0] tg);
    @(negedge clk);
    lk_pc = pc;
    expect_lk(name, h, t, tg);
    #2 check_lk();
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // One-cycle update strobe. The bench model tracks the statistics counters.
  task automatic update(input logic [31:0] pc, input logic [31:0] tg, input logic t, input logic pt);
    @(negedge clk);
    up_valid = 1'b1; up_pc = pc; up_target = tg; up_taken = t; up_pred_taken = pt;
    @(negedge clk);
    up_valid = 1'b0;
    exp_upd = sat16(exp_upd + 1);
    if (t != pt) exp_mis = sat16(exp_mis + 1);
  endtask

  // Counts busy cycles after reset drops. The bound keeps a stuck busy from hanging the run.
  task automatic wait_init(input string name, input bit drop_upd);
    int n = 0;
    while (busy && n < 100) begin
      lk_pc = $urandom();
      #1 chk({name, "_init_nohit"}, {31'd0, pred_hit}, 32'd0);
      if (drop_upd && n == 3) begin
        up_valid = 1'b1; up_pc = 32'h40; up_target = 32'h100;
        up_taken = 1'b1; up_pred_taken = 1'b0;
      end else begin
        up_valid = 1'b0;
      end
      n++;
      @(negedge clk); #2;
    end
    up_valid = 1'b0;
    chk({name, "_busy_cycles"}, n, 32'd16);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    lk_pc = 32'h40;
    @(negedge clk); #2;
    chk({name, "_rst_busy"},   {31'd0, busy},       32'd1);
    chk({name, "_rst_hit"},    {31'd0, pred_hit},   32'd0);
    chk({name, "_rst_taken"},  {31'd0, pred_taken}, 32'd0);
    chk({name, "_rst_target"}, pred_target,         32'd0);
    chk({name, "_rst_stu"},    {16'd0, stat_updates},     32'd0);
    chk({name, "_rst_stm"},    {16'd0, stat_mispredicts}, 32'd0);
    reset = 1'b0;
    exp_upd = 0; exp_mis = 0;
  endtask

  initial begin
    // Power-up: a one-cycle reset, then an update that arrives during INIT and must be dropped.
    do_reset("por");
    wait_init("por", 1'b1);
    lookup("init_upd_dropped", 32'h40, 1'b0, 1'b0, 32'h0);
    chk("stat_upd_after_init", {16'd0, stat_updates}, 32'd0);
    for (int i = 0; i < 4; i++)
      lookup("run_empty", $urandom(), 1'b0, 1'b0, 32'h0);

    // Allocation, then counter training down to the bottom.
    update(32'h40, 32'h100, 1'b1, 1'b0);
    lookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    update(32'h40, 32'h999, 1'b0, 1'b1);
    lookup("nt1_ctr1", 32'h40, 1'b1, 1'b0, 32'h0);
    update(32'h40, 32'h999, 1'b0, 1'b0);
    lookup("nt2_ctr0", 32'h40, 1'b1, 1'b0, 32'h0);
    update(32'h40, 32'h999, 1'b0, 1'b0);
    lookup("nt3_ctr0", 32'h40, 1'b1, 1'b0, 32'h0);

    // Climb back up, saturate at 3, then come down again. Taken updates retarget the entry.
    update(32'h40, 32'h200, 1'b1, 1'b0);
    lookup("t1_ctr1", 32'h40, 1'b1, 1'b0, 32'h0);
    update(32'h40, 32'h200, 1'b1, 1'b0);
    lookup("t2_ctr2", 32'h40, 1'b1, 1'b1, 32'h200);
    update(32'h40, 32'h200, 1'b1, 1'b1);
    update(32'h40, 32'h200, 1'b1, 1'b1);
    update(32'h40, 32'h200, 1'b1, 1'b1);
    lookup("sat_ctr3", 32'h40, 1'b1, 1'b1, 32'h200);
    update(32'h40, 32'h777, 1'b0, 1'b1);
    lookup("sat_nt_ctr2", 32'h40, 1'b1, 1'b1, 32'h200);
    update(32'h40, 32'h777, 1'b0, 1'b1);
    lookup("sat_nt_ctr1", 32'h40, 1'b1, 1'b0, 32'h0);

    // An aliasing taken branch replaces the entry. The low PC bits do not matter.
    update(32'h440, 32'h300, 1'b1, 1'b0);
    lookup("alias_old_miss", 32'h40,  1'b0, 1'b0, 32'h0);
    lookup("alias_new_hit",  32'h440, 1'b1, 1'b1, 32'h300);
    lookup("alias_lowbits",  32'h443, 1'b1, 1'b1, 32'h300);
    // A not-taken miss allocates nothing.
    update(32'h80, 32'h900, 1'b0, 1'b0);
    lookup("nt_miss_noalloc", 32'h80,  1'b0, 1'b0, 32'h0);
    lookup("nt_miss_keep",    32'h440, 1'b1, 1'b1, 32'h300);

    // A same-cycle lookup sees the old value. The new one appears after the edge.
    @(negedge clk);
    lk_pc = 32'h440;
    up_valid = 1'b1; up_pc = 32'h440; up_target = 32'h500; up_taken = 1'b1; up_pred_taken = 1'b1;
    expect_lk("same_cycle_old", 1'b1, 1'b1, 32'h300);
    #2 check_lk();
    @(negedge clk);
    up_valid = 1'b0;
    exp_upd = sat16(exp_upd + 1);
    expect_lk("same_cycle_new", 1'b1, 1'b1, 32'h500);
    #2 check_lk();
    @(negedge clk);
    lk_pc = 32'h40;
    up_valid = 1'b1; up_pc = 32'h40; up_target = 32'h600; up_taken = 1'b1; up_pred_taken = 1'b0;
    expect_lk("same_cycle_alloc_old", 1'b0, 1'b0, 32'h0);
    #2 check_lk();
    @(negedge clk);
    up_valid = 1'b0;
    exp_upd = sat16(exp_upd + 1);
    exp_mis = sat16(exp_mis + 1);
    expect_lk("same_cycle_alloc_new", 1'b1, 1'b1, 32'h600);
    #2 check_lk();

    chk("stat_updates",     {16'd0, stat_updates},     exp_upd);
    chk("stat_mispredicts", {16'd0, stat_mispredicts}, exp_mis);

    // Reset mid-RUN wipes every hit. A second reset lands partway through the INIT sweep.
    do_reset("run_rst");
    repeat (5) @(negedge clk);
    do_reset("mid_init_rst");
    wait_init("mid_init_rst", 1'b0);
    lookup("stale_40",  32'h40,  1'b0, 1'b0, 32'h0);
    lookup("stale_440", 32'h440, 1'b0, 1'b0, 32'h0);

    // 70000 back-to-back mispredicting updates drive both counters into saturation.
    @(negedge clk);
    up_valid = 1'b1; up_pc = 32'h40; up_target = 32'h100; up_taken = 1'b1; up_pred_taken = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      exp_upd = sat16(exp_upd + 1);
      exp_mis = sat16(exp_mis + 1);
      if (i == 99) begin
        #2;
        chk("stat_upd_100", {16'd0, stat_updates},     exp_upd);
        chk("stat_mis_100", {16'd0, stat_mispredicts}, exp_mis);
      end
    end
    up_valid = 1'b0;
    #2;
    chk("stat_upd_sat", {16'd0, stat_updates},     exp_upd);
    chk("stat_mis_sat", {16'd0, stat_mispredicts}, exp_mis);
    chk("stat_upd_ffff", {16'd0, stat_updates},    32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and target width.
REQ-002 SHALL have parameter IDX_W, default 4, table index bits (DEPTH = 2**IDX_W entries).
REQ-003 SHALL have parameter TAG_W, default 8, stored tag bits.
REQ-004 SHALL have parameter CTR_W, default 2, saturating counter width (legal range 1..4).
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port lk_pc  input  ADDR_W  fetch-stage PC to predict.
REQ-008 SHALL have port pred_hit  output  1  valid entry with matching tag for lk_pc.
REQ-009 SHALL have port pred_taken  output  1  predict taken.
REQ-010 SHALL have port pred_target  output  ADDR_W  predicted target; all zeros when pred_taken=0.
REQ-011 SHALL have port up_valid  input  1  resolved-branch update strobe.
REQ-012 SHALL have port up_pc, up_target  input  ADDR_W each  resolved branch PC and actual target.
REQ-013 SHALL have port up_taken, up_pred_taken  input  1 each  actual outcome; prediction made earlier.
REQ-014 SHALL have port busy  output  1  table initialisation in progress.
REQ-015 SHALL have port stat_updates, stat_mispredicts  output  16 each  event counters.

Function
REQ-016 SHALL compute index = pc[IDX_W+1:2] and tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
REQ-017 SHALL store per entry: valid (1), tag (TAG_W), counter (CTR_W), target (ADDR_W).
REQ-018 SHALL produce lookup outputs combinationally from the registered table, zero-cycle latency.
REQ-019 SHALL assert pred_hit iff not busy, entry valid and tag equal; pred_taken iff pred_hit and counter MSB = 1.
REQ-020 SHALL implement FSM INIT -> RUN: INIT clears valid of one entry per cycle, index 0..DEPTH-1, then enters RUN.
REQ-021 SHALL hold busy=1 exactly DEPTH cycles after reset deassertion; busy=0 in RUN.
REQ-022 SHALL drop up_valid updates while busy; counters unchanged.
REQ-023 SHALL, on RUN update hit: counter +1 saturating at 2**CTR_W-1 if up_taken, else -1 saturating at 0; target := up_target if up_taken.
REQ-024 SHALL, on RUN update miss with up_taken=1: allocate (overwrite) entry; valid=1, tag, target=up_target, counter=2**(CTR_W-1) (weakly taken).
REQ-025 SHALL, on RUN update miss with up_taken=0: leave table unchanged.
REQ-026 SHALL make update writes visible to lookup on the next cycle; same-cycle lookup of the updated index returns pre-update contents.
REQ-027 SHALL increment stat_updates on each accepted update; stat_mispredicts when accepted and up_taken != up_pred_taken; both saturate at 16'hFFFF.

Reset
REQ-028 SHALL, while reset=1: state := INIT, init index := 0, stat counters := 0, busy=1, pred_hit=0, pred_taken=0, pred_target=0.
REQ-029 SHALL restart INIT from index 0 if reset asserts mid-INIT or in RUN; prior table contents never hit afterwards.
REQ-030 SHALL leave tag, counter and target storage uncleared by reset (only valid bits cleared through INIT).

Verification
REQ-031 SHALL cover: reset 1 cycle then idle -> busy=1 for exactly 16 cycles, then 0; pred_hit=0 for all lk_pc.
REQ-032 SHALL cover: RUN, update up_pc=0x40, taken, target=0x100 -> next cycle lk_pc=0x40 gives hit=1, taken=1, target=0x100, counter=2.
REQ-033 SHALL cover: then three not-taken updates at 0x40 -> counter 1,0,0; pred_taken=0, pred_hit=1, pred_target=0.
REQ-034 SHALL cover: alias up_pc=0x440 taken (same index, different tag) -> lk_pc=0x40 misses, 0x440 hits.
REQ-035 SHALL cover: update during INIT and 70000 mispredicting updates in RUN -> INIT update dropped; both stat counters hold at 0xFFFF.
REQ-036 SHALL cover: same-cycle lookup and update of 0x40 -> lookup shows old value, new value next cycle; reset mid-RUN -> busy 16 cycles, no stale hits.
